// File: rtl/uart_mmio.sv
// Memory-mapped UART: one TX and one RX byte, 16x oversampling, irq to control unit.
// Define UART_IRQ_EN to make CON[1:0] writable and drive irqout; otherwise both read/tie 0.
module uart_mmio #(
    parameter int CLK_HZ = 25000000,
    parameter int BAUD   = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irqout
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    logic       txd_wr, rxd_rd, con_rd, con_wr;

    logic [1:0] tx_st_q, tx_st_d;
    logic [3:0] tx_tc_q, tx_tc_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       tx_line_q, tx_line_d;
    logic       tx_fin, tx_busy;

    logic [1:0] rx_sync_q, rx_sync_d;
    logic       rx_prev_q, rx_s, rx_fall;
    logic [1:0] rx_st_q, rx_st_d;
    logic [3:0] rx_tc_q, rx_tc_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic       rx_ok, rx_ferr;

    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_done_q, tx_done_d;
    logic       ovr_q, ovr_d;
    logic       ferr_q, ferr_d;
    logic [1:0] en_q, en_d;
    logic       irq_q, irq_d;
    logic [31:0] con_val;
    logic       unused_ok;

    assign tick    = (cnt_q == DIV_M1);
    assign cnt_d   = tick ? '0 : cnt_q + 1'b1;

    assign txd_wr  = wr & (addr == A_TXD);
    assign rxd_rd  = rd & (addr == A_RXD);
    assign con_rd  = rd & (addr == A_CON);
    assign con_wr  = wr & (addr == A_CON);

    assign tx_busy = (tx_st_q != S_IDLE);
    assign UART_TX = tx_line_q;
    assign irqout  = irq_q;

    assign rx_sync_d = {rx_sync_q[0], UART_RX};
    assign rx_s      = rx_sync_q[1];
    assign rx_fall   = rx_prev_q & ~rx_s;

    assign unused_ok = ^{wdata[31:8], con_wr};

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_tc_d   = tx_tc_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_line_d = tx_line_q;
        tx_fin    = 1'b0;
        unique case (tx_st_q)
            S_IDLE: begin
                if (txd_wr) begin
                    tx_sh_d   = wdata[7:0];
                    tx_st_d   = S_START;
                    tx_tc_d   = 4'd0;
                    tx_line_d = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_tc_d = tx_tc_q + 4'd1;
                    if (tx_tc_q == 4'd15) begin
                        tx_st_d   = S_DATA;
                        tx_bit_d  = 3'd0;
                        tx_line_d = tx_sh_q[0];
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    tx_tc_d = tx_tc_q + 4'd1;
                    if (tx_tc_q == 4'd15) begin
                        if (tx_bit_q == 3'd7) begin
                            tx_st_d   = S_STOP;
                            tx_line_d = 1'b1;
                        end else begin
                            tx_bit_d  = tx_bit_q + 3'd1;
                            tx_sh_d   = {1'b0, tx_sh_q[7:1]};
                            tx_line_d = tx_sh_q[1];
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    tx_tc_d = tx_tc_q + 4'd1;
                    if (tx_tc_q == 4'd15) begin
                        tx_st_d = S_IDLE;
                        tx_fin  = 1'b1;
                    end
                end
            end
            default: tx_st_d = S_IDLE;
        endcase
    end

    // START waits half a bit (8 ticks) so later samples land mid-bit
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_tc_d  = rx_tc_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_ok    = 1'b0;
        rx_ferr  = 1'b0;
        unique case (rx_st_q)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_st_d = S_START;
                    rx_tc_d = 4'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    rx_tc_d = rx_tc_q + 4'd1;
                    if (rx_tc_q == 4'd7) begin
                        rx_tc_d  = 4'd0;
                        rx_bit_d = 3'd0;
                        rx_st_d  = rx_s ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    rx_tc_d = rx_tc_q + 4'd1;
                    if (rx_tc_q == 4'd15) begin
                        rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                        rx_bit_d = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_st_d = S_STOP;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    rx_tc_d = rx_tc_q + 4'd1;
                    if (rx_tc_q == 4'd15) begin
                        rx_st_d = S_IDLE;
                        rx_ok   = rx_s;
                        rx_ferr = ~rx_s;
                    end
                end
            end
            default: rx_st_d = S_IDLE;
        endcase
    end

    // Set conditions take priority over read-to-clear
    always_comb begin
        rx_data_d  = rx_ok ? rx_sh_q : rx_data_q;
        rx_valid_d = rx_ok ? 1'b1 : (rxd_rd ? 1'b0 : rx_valid_q);
        ovr_d      = (rx_ok & rx_valid_q) ? 1'b1 : (con_rd ? 1'b0 : ovr_q);
        ferr_d     = rx_ferr ? 1'b1 : (con_rd ? 1'b0 : ferr_q);
        tx_done_d  = tx_fin ? 1'b1 : (con_rd ? 1'b0 : tx_done_q);
`ifdef UART_IRQ_EN
        en_d       = con_wr ? wdata[1:0] : en_q;
        irq_d      = (en_q[0] & tx_done_q) | (en_q[1] & rx_valid_q);
`else
        en_d       = 2'b00;
        irq_d      = 1'b0;
`endif
    end

    assign con_val = {25'd0, ferr_q, ovr_q, tx_busy, tx_done_q, rx_valid_q, en_q};

    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            if (addr == A_RXD) begin
                rdata = {24'd0, rx_data_q};
            end else if (addr == A_CON) begin
                rdata = con_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            tx_st_q    <= S_IDLE;
            tx_tc_q    <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'd0;
            tx_line_q  <= 1'b1;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= S_IDLE;
            rx_tc_q    <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            en_q       <= 2'b00;
            irq_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tx_st_q    <= tx_st_d;
            tx_tc_q    <= tx_tc_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_line_q  <= tx_line_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_s;
            rx_st_q    <= rx_st_d;
            rx_tc_q    <= rx_tc_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_done_q  <= tx_done_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            en_q       <= en_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio at DIV = 4 (one bit = 64 cycles).
// Irq expectations follow UART_IRQ_EN.
module tb_uart_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        UART_RX;
    logic        UART_TX;
    logic        irqout;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;
`ifdef UART_IRQ_EN
    localparam logic [31:0] EN2    = 32'h2;
    localparam logic [31:0] IRQ_ON = 32'h1;
`else
    localparam logic [31:0] EN2    = 32'h0;
    localparam logic [31:0] IRQ_ON = 32'h0;
`endif

    uart_mmio #(.CLK_HZ(1600000), .BAUD(25000)) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .UART_RX(UART_RX),
        .UART_TX(UART_TX),
        .irqout (irqout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // combinational look at rdata, no clock edge so no side effects
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1;
        addr = a;
        #1;
        d = rdata;
        rd = 1'b0;
        addr = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        rd = 1'b1;
        addr = a;
        #1;
        d = rdata;
        @(posedge clk);
        #1;
        rd = 1'b0;
        addr = 32'd0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        wr = 1'b1;
        addr = a;
        wdata = v;
        @(posedge clk);
        #1;
        wr = 1'b0;
        addr = 32'd0;
        wdata = 32'd0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        UART_RX = 1'b0;
        repeat (64) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (64) @(posedge clk);
        end
        UART_RX = stopb;
        repeat (64) @(posedge clk);
        UART_RX = 1'b1;
    endtask

    task automatic wait_rx_valid(output logic ok);
        logic [31:0] d;
        ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            peek(CON, d);
            if (d[2]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [9:0]  exp_bits;
        logic        ok;

        reset = 1'b1;
        rd = 1'b0;
        wr = 1'b0;
        addr = 32'd0;
        wdata = 32'd0;
        UART_RX = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(posedge clk);
        #1;

        chk("rst_tx", UART_TX, 1);
        chk("rst_irq", irqout, 0);
        addr = CON;
        #1;
        chk("rdata_no_rd", rdata, 0);
        addr = 32'd0;
        peek(CON, d);
        chk("rst_con", d, 32'h0);

        // TX frame 0xA5 with an ignored 0x55 write one cycle later
        exp_bits = {1'b1, 8'hA5, 1'b0};
        bus_write(TXD, 32'h0000_00A5);
        chk("tx_start_line", UART_TX, 0);
        peek(CON, d);
        chk("tx_start_con", d, 32'h10);
        peek(TXD, d);
        chk("txd_read_zero", d, 0);
        bus_write(TXD, 32'h0000_0055);
        repeat (31) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tx_bit%0d", i), UART_TX, exp_bits[i]);
            peek(CON, d);
            chk($sformatf("tx_busy%0d", i), d[4], 1);
            if (i < 9) begin
                repeat (64) @(posedge clk);
                #1;
            end
        end
        repeat (42) @(posedge clk);
        #1;
        bus_read(CON, d);
        chk("tx_done_con", d, 32'h08);
        peek(CON, d);
        chk("tx_done_clr", d, 32'h00);
        repeat (200) @(posedge clk);
        #1;
        chk("tx_no_second", UART_TX, 1);
        peek(CON, d);
        chk("tx_no_second_con", d, 32'h00);

        // RX 0x3C with RX irq enabled
        bus_write(CON, 32'h2);
        peek(CON, d);
        chk("con_en", d, EN2);
        fork
            send_rx(8'h3C, 1'b1);
            begin
                wait_rx_valid(ok);
                chk("rx3c_seen", ok, 1);
                chk("irq_lag0", irqout, 0);
                @(posedge clk);
                #1;
                chk("irq_rise", irqout, IRQ_ON);
            end
        join
        peek(RXD, d);
        chk("rx3c_peek", d, 32'h3C);
        bus_read(RXD, d);
        chk("rx3c_read", d, 32'h3C);
        chk("irq_hold", irqout, IRQ_ON);
        @(posedge clk);
        #1;
        chk("irq_fall", irqout, 0);
        peek(CON, d);
        chk("rx3c_con", d, EN2);
        bus_write(CON, 32'h0);

        // overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        peek(RXD, d);
        chk("ovr_data", d, 32'h22);
        bus_read(CON, d);
        chk("ovr_con", d, 32'h24);
        peek(CON, d);
        chk("ovr_clr", d, 32'h04);
        bus_read(RXD, d);
        chk("ovr_rxd", d, 32'h22);
        peek(CON, d);
        chk("ovr_empty", d, 32'h00);

        // framing error
        send_rx(8'h5A, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        bus_read(CON, d);
        chk("ferr_con", d, 32'h40);
        peek(CON, d);
        chk("ferr_clr", d, 32'h00);

        // 1-tick glitch, then a clean byte
        UART_RX = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        UART_RX = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        peek(CON, d);
        chk("glitch_con", d, 32'h00);
        send_rx(8'h81, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        bus_read(RXD, d);
        chk("after_glitch", d, 32'h81);

        // reset mid-frame, during data bit1 (0)
        bus_write(TXD, 32'h0000_00A5);
        repeat (150) @(posedge clk);
        #1;
        chk("mid_line", UART_TX, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_line", UART_TX, 1);
        peek(CON, d);
        chk("rst_mid_con", d, 32'h00);
        chk("rst_mid_irq", irqout, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        chk("post_rst_line", UART_TX, 1);
        peek(CON, d);
        chk("post_rst_con", d, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
